tour_seq: RTL
=============

TOUR_SEQ -- requirements
Module: tour_seq

Interface
REQ-001 Parameter NUM_MOVES, default 24, is the number of knight moves replayed per tour; legal range is 2..63.
REQ-002 Parameter IDX_W, default $clog2(NUM_MOVES), is the width of mv_indx.
REQ-003 clk  input  1  system clock; the block has one clock domain.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 start_tour  input  1  one-cycle pulse that starts a tour.
REQ-006 move  input  8  one-hot move code at address mv_indx.
REQ-007 mv_indx  output  IDX_W  index of the move being replayed.
REQ-008 cmd_UART  input  16  command from the UART wrapper.
REQ-009 cmd_rdy_UART  input  1  cmd_UART valid.
REQ-010 cmd  output  16  command forwarded to cmd_proc.
REQ-011 cmd_rdy  output  1  cmd valid to cmd_proc.
REQ-012 clr_cmd_rdy  input  1  cmd_proc accepted cmd.
REQ-013 send_resp  input  1  cmd_proc finished the current command.
REQ-014 resp  output  8  response byte for the UART.
REQ-015 tour_busy  output  1  high while a tour is active.
REQ-016 tour_err  output  1  one-cycle pulse on an illegal move or an abort.

Function
REQ-017 States SHALL be IDLE, V_ISSUE, V_WAIT, H_ISSUE, H_WAIT.
REQ-018 IDLE: cmd=cmd_UART, cmd_rdy=cmd_rdy_UART, tour_busy=0; start_tour zeroes mv_indx and moves to V_ISSUE next cycle.
REQ-019 Outside IDLE: cmd=tour leg command, tour_busy=1; cmd_rdy=1 only in V_ISSUE/H_ISSUE.
REQ-020 V_ISSUE->V_WAIT on clr_cmd_rdy; V_WAIT->H_ISSUE on send_resp; H_ISSUE->H_WAIT on clr_cmd_rdy.
REQ-021 H_WAIT on send_resp: if mv_indx==NUM_MOVES-1 go to IDLE with mv_indx held; otherwise increment mv_indx and go to V_ISSUE.
REQ-022 Leg command format is {3'b010, fanfare, heading[7:0], squares[3:0]}; fanfare=1 exactly when squares==1.
REQ-023 Vertical leg: bits 0,1 give N2; bits 2,7 give N1; bits 3,6 give S1; bits 4,5 give S2.
REQ-024 Horizontal leg: bits 1,4 give E1; bits 2,3 give E2; bits 0,5 give W1; bits 6,7 give W2.
REQ-025 Headings: N=8'h00, S=8'h7F, E=8'h3F, W=8'hBF.
REQ-026 A non-one-hot move (zero or multi-bit) sampled in V_ISSUE SHALL pulse tour_err and go to IDLE; no cmd_rdy is asserted that cycle.
REQ-027 resp SHALL be 8'hA5 in IDLE, 8'hA5 in H_WAIT when mv_indx==NUM_MOVES-1, and 8'h5A in all other tour states.
REQ-028 The leg command SHALL stay stable from the ISSUE state through the matching WAIT state.
REQ-029 start_tour while tour_busy SHALL be ignored.
REQ-030 If clr_cmd_rdy and send_resp arrive in the same cycle in an ISSUE state, only clr_cmd_rdy is acted on.

Reset
REQ-031 rst_n low SHALL asynchronously set state=IDLE and mv_indx=0; outputs then take their IDLE values.
REQ-032 Reset mid-tour SHALL abandon the tour with no tour_err pulse.

Configuration
REQ-033 With TOUR_ABORT_EN defined: cmd_rdy_UART=1 in any non-IDLE state SHALL pulse tour_err and return to IDLE next cycle; the UART command is not forwarded in that cycle and stays pending in the wrapper.
REQ-034 Without TOUR_ABORT_EN: cmd_rdy_UART is ignored during a tour.

Structure
REQ-035 Package tour_pkg SHALL hold the state enum, the heading constants, CMD_MOVE=3'b010, RESP_PEND=8'h5A and RESP_DONE=8'hA5.
REQ-036 Combinational sub-module tour_leg_decode (inputs move, leg_sel; outputs cmd[15:0], legal) SHALL perform the move decode.

Verification
REQ-037 NUM_MOVES=24, all moves 8'h01: each move produces cmd 16'h4002 then 16'h5BF1; 48 legs total; final resp 8'hA5; back in IDLE.
REQ-038 move=8'h08: vertical leg 16'h57F1, horizontal leg 16'h43F2.
REQ-039 move=8'h00 at mv_indx=5: tour_err pulses, state is IDLE, mv_indx stays 5.
REQ-040 TOUR_ABORT_EN defined, cmd_rdy_UART asserted in V_WAIT: tour_err pulses and next-cycle cmd equals cmd_UART; without the macro the tour continues.
REQ-041 NUM_MOVES=3: mv_indx runs 0..2, resp reads 8'hA5 only in the final H_WAIT, and a start_tour pulse mid-tour is ignored.
REQ-042 rst_n asserted in H_ISSUE: state=IDLE and mv_indx=0 asynchronously; cmd_rdy follows cmd_rdy_UART.

Source files
------------

// File: rtl/tour_pkg.sv
// tour_pkg: shared state encoding, heading codes and command/response constants
// for the knight-tour replay sequencer.
`default_nettype none

package tour_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_V_ISSUE = 3'd1,
        ST_V_WAIT  = 3'd2,
        ST_H_ISSUE = 3'd3,
        ST_H_WAIT  = 3'd4
    } state_e;

    localparam logic [7:0] HEAD_N    = 8'h00;
    localparam logic [7:0] HEAD_S    = 8'h7F;
    localparam logic [7:0] HEAD_E    = 8'h3F;
    localparam logic [7:0] HEAD_W    = 8'hBF;

    localparam logic [2:0] CMD_MOVE  = 3'b010;
    localparam logic [7:0] RESP_PEND = 8'h5A;
    localparam logic [7:0] RESP_DONE = 8'hA5;

    // Fanfare is requested only on single-square legs.
    function automatic logic [15:0] leg_cmd(input logic [7:0] heading, input logic [3:0] squares);
        return {CMD_MOVE, (squares == 4'd1), heading, squares};
    endfunction

endpackage

`default_nettype wire

// File: rtl/tour_leg_decode.sv
// tour_leg_decode: turns a one-hot knight move into the vertical (leg_sel=0)
// or horizontal (leg_sel=1) move command and flags whether the move is one-hot.
`default_nettype none

module tour_leg_decode (
    input  logic [7:0]  move,
    input  logic        leg_sel,
    output logic [15:0] cmd,
    output logic        legal
);
    import tour_pkg::*;

    logic [7:0] w_heading;
    logic [3:0] w_squares;

    always_comb begin
        w_heading = HEAD_N;
        w_squares = 4'd0;
        if (!leg_sel) begin
            if (|(move & 8'h03)) begin
                w_heading = HEAD_N;
                w_squares = 4'd2;
            end else if (|(move & 8'h84)) begin
                w_heading = HEAD_N;
                w_squares = 4'd1;
            end else if (|(move & 8'h48)) begin
                w_heading = HEAD_S;
                w_squares = 4'd1;
            end else if (|(move & 8'h30)) begin
                w_heading = HEAD_S;
                w_squares = 4'd2;
            end
        end else begin
            if (|(move & 8'h12)) begin
                w_heading = HEAD_E;
                w_squares = 4'd1;
            end else if (|(move & 8'h0C)) begin
                w_heading = HEAD_E;
                w_squares = 4'd2;
            end else if (|(move & 8'h21)) begin
                w_heading = HEAD_W;
                w_squares = 4'd1;
            end else if (|(move & 8'hC0)) begin
                w_heading = HEAD_W;
                w_squares = 4'd2;
            end
        end
    end

    assign cmd   = leg_cmd(w_heading, w_squares);
    assign legal = (move != 8'd0) && ((move & (move - 8'd1)) == 8'd0);

endmodule

`default_nettype wire

// File: rtl/tour_seq.sv
// tour_seq: replays NUM_MOVES knight moves as vertical/horizontal leg commands,
// muxing with UART commands when idle. Define TOUR_ABORT_EN to abort on UART traffic.
`default_nettype none

module tour_seq #(
    parameter int NUM_MOVES = 24,
    parameter int IDX_W     = $clog2(NUM_MOVES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_tour,
    input  logic [7:0]       move,
    output logic [IDX_W-1:0] mv_indx,
    input  logic [15:0]      cmd_UART,
    input  logic             cmd_rdy_UART,
    output logic [15:0]      cmd,
    output logic             cmd_rdy,
    input  logic             clr_cmd_rdy,
    input  logic             send_resp,
    output logic [7:0]       resp,
    output logic             tour_busy,
    output logic             tour_err
);
    import tour_pkg::*;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MOVES - 1);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [IDX_W-1:0] r_mv_indx;
    logic [IDX_W-1:0] w_mv_indx_nxt;
    logic [15:0]      r_leg_cmd;
    logic [15:0]      w_dec_cmd;
    logic             w_leg_sel;
    logic             w_legal;
    logic             w_abort;
    logic             w_issue;
    logic             w_last;
    logic             w_err;

    assign w_leg_sel = (r_state == ST_H_ISSUE) || (r_state == ST_H_WAIT);
    assign w_issue   = (r_state == ST_V_ISSUE) || (r_state == ST_H_ISSUE);
    assign w_last    = (r_mv_indx == LAST_IDX);

    tour_leg_decode u_leg_decode (
        .move    (move),
        .leg_sel (w_leg_sel),
        .cmd     (w_dec_cmd),
        .legal   (w_legal)
    );

`ifdef TOUR_ABORT_EN
    assign w_abort = (r_state != ST_IDLE) && cmd_rdy_UART;
`else
    assign w_abort = 1'b0;
`endif

    always_comb begin
        w_state_nxt   = r_state;
        w_mv_indx_nxt = r_mv_indx;
        w_err         = 1'b0;
        if (w_abort) begin
            w_state_nxt = ST_IDLE;
            w_err       = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start_tour) begin
                        w_state_nxt   = ST_V_ISSUE;
                        w_mv_indx_nxt = '0;
                    end
                end
                ST_V_ISSUE: begin
                    if (!w_legal) begin
                        w_state_nxt = ST_IDLE;
                        w_err       = 1'b1;
                    end else if (clr_cmd_rdy) begin
                        w_state_nxt = ST_V_WAIT;
                    end
                end
                ST_V_WAIT: begin
                    if (send_resp) w_state_nxt = ST_H_ISSUE;
                end
                ST_H_ISSUE: begin
                    if (clr_cmd_rdy) w_state_nxt = ST_H_WAIT;
                end
                ST_H_WAIT: begin
                    if (send_resp) begin
                        if (w_last) begin
                            w_state_nxt = ST_IDLE;
                        end else begin
                            w_state_nxt   = ST_V_ISSUE;
                            w_mv_indx_nxt = r_mv_indx + IDX_W'(1);
                        end
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_mv_indx <= '0;
            r_leg_cmd <= 16'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_mv_indx <= w_mv_indx_nxt;
            // Captured while issuing so the command cannot drift during the wait.
            if (w_issue) r_leg_cmd <= w_dec_cmd;
        end
    end

    always_comb begin
        cmd     = cmd_UART;
        cmd_rdy = cmd_rdy_UART;
        if (r_state != ST_IDLE) begin
            cmd     = w_issue ? w_dec_cmd : r_leg_cmd;
            cmd_rdy = w_issue && !w_abort && !((r_state == ST_V_ISSUE) && !w_legal);
        end
    end

    assign resp      = ((r_state == ST_IDLE) || ((r_state == ST_H_WAIT) && w_last)) ? RESP_DONE : RESP_PEND;
    assign tour_busy = (r_state != ST_IDLE);
    assign tour_err  = w_err;
    assign mv_indx   = r_mv_indx;

endmodule

`default_nettype wire
